i2s_rx: RTL and testbench

- I2S slave receiver; the receive-side counterpart of the team's I2S master transmitter.
- Samples externally driven bclk/lrclk/data, synchronises them into clk, and assembles 16-bit left/right words into 32-bit frames.
- Frames are buffered in a small FIFO and drained by a valid/ready stream or by EVB register reads.
- The EVB command port matches the transmitter's register-bus protocol.

---
 rtl/i2s_rx_pkg.sv | 51 +++++
 rtl/i2s_rx_fifo.sv | 51 +++++
 rtl/i2s_rx.sv | 194 +++++++++++++++++++
 tb/tb_i2s_rx.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_rx_pkg.sv
// Shared definitions for the I2S slave receiver: register map, EVB masks,
// STATUS bit layout, capture FSM states and the masked-write helper.
package i2s_rx_pkg;

  localparam int WORD_W  = 16;
  localparam int FRAME_W = 32;
  localparam int CNT_W   = 5;

  localparam logic [1:0] EVB_MASK_DUMMY = 2'b00;
  localparam logic [1:0] EVB_MASK_L     = 2'b01;
  localparam logic [1:0] EVB_MASK_H     = 2'b10;
  localparam logic [1:0] EVB_MASK_W     = 2'b11;

  localparam logic [3:0] RX_STATUS_ISSUE = 4'd0;
  localparam logic [3:0] RX_LEVEL_ISSUE  = 4'd1;
  localparam logic [3:0] RX_DATA_ISSUE   = 4'd2;

  localparam int ST_BUSY  = 0;
  localparam int ST_EN    = 1;
  localparam int ST_EMPTY = 2;
  localparam int ST_OVF   = 3;

  typedef enum logic [1:0] {
    CAP_IDLE,
    CAP_ALIGN,
    CAP_SHIFT
  } cap_state_e;

  function automatic logic [31:0] evb_compose(input logic [1:0]  mask,
                                              input logic [31:0] cur,
                                              input logic [31:0] wdata);
    case (mask)
      EVB_MASK_W: evb_compose = wdata;
      EVB_MASK_H: evb_compose = {wdata[31:16], cur[15:0]};
      EVB_MASK_L: evb_compose = {cur[31:16], wdata[15:0]};
      default:    evb_compose = cur;
    endcase
  endfunction

  // Single bit of the composed write word; keeps callers from carrying
  // a full word when only a couple of control bits are writable.
  function automatic logic evb_wr_bit(input logic [1:0]  mask,
                                      input logic [31:0] cur,
                                      input logic [31:0] wdata,
                                      input int          idx);
    logic [31:0] w;
    w = evb_compose(mask, cur, wdata);
    evb_wr_bit = w[idx];
  endfunction

endpackage

// File: rtl/i2s_rx_fifo.sv
// Synchronous frame FIFO; a push into a full FIFO is dropped unless a pop
// frees the slot in the same cycle.
module i2s_rx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [LW-1:0]    count;
  logic             push_ok, pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == LW'(DEPTH));
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign drop    = push & full & ~pop_ok;
  assign level   = count;
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + LW'(push_ok) - LW'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/i2s_rx.sv
// I2S slave receiver: synchronises bclk/lrclk/data, assembles 16-bit
// chan0/chan1 words into frames, buffers them and exposes stream + EVB access.
module i2s_rx
  import i2s_rx_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        io_i2s_bclk,
  input  logic        io_i2s_lrclk,
  input  logic        io_i2s_data,
  input  logic        evb_cmd_request,
  input  logic [3:0]  evb_cmd_addr,
  input  logic [1:0]  evb_cmd_wr_mask,
  input  logic [31:0] evb_cmd_wr_data,
  output logic        evb_cmd_finish,
  output logic [31:0] evb_cmd_rd_data,
  output logic        rx_valid,
  output logic [31:0] rx_data,
  input  logic        rx_ready
);

  // ---------------- input synchronisers ----------------
  logic [SYNC_STAGES-1:0] bclk_sync, lr_sync, data_sync;
  logic                   bclk_hist, lr_hist;
  logic                   bclk_s, lr_s, data_s, bclk_rise, lr_edge;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bclk_sync <= '0;
      lr_sync   <= '0;
      data_sync <= '0;
      bclk_hist <= 1'b0;
      lr_hist   <= 1'b0;
    end else begin
      bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], io_i2s_bclk};
      lr_sync   <= {lr_sync[SYNC_STAGES-2:0], io_i2s_lrclk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], io_i2s_data};
      bclk_hist <= bclk_s;
      lr_hist   <= lr_s;
    end
  end

  assign bclk_s    = bclk_sync[SYNC_STAGES-1];
  assign lr_s      = lr_sync[SYNC_STAGES-1];
  assign data_s    = data_sync[SYNC_STAGES-1];
  assign bclk_rise = bclk_s & ~bclk_hist;
  assign lr_edge   = lr_s ^ lr_hist;

  // ---------------- capture FSM ----------------
  cap_state_e        state, state_n;
  logic              chan, chan_n;
  logic [CNT_W-1:0]  bitcnt, bitcnt_n;
  logic [WORD_W-1:0] shift_q, shift_n, low_q, low_n;
  logic              half_ok, half_ok_n;
  logic              frame_push;
  logic              en, overflow, busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= CAP_IDLE;
      chan    <= 1'b0;
      bitcnt  <= '0;
      shift_q <= '0;
      low_q   <= '0;
      half_ok <= 1'b0;
    end else begin
      state   <= state_n;
      chan    <= chan_n;
      bitcnt  <= bitcnt_n;
      shift_q <= shift_n;
      low_q   <= low_n;
      half_ok <= half_ok_n;
    end
  end

  always_comb begin
    state_n    = state;
    chan_n     = chan;
    bitcnt_n   = bitcnt;
    shift_n    = shift_q;
    low_n      = low_q;
    half_ok_n  = half_ok;
    frame_push = 1'b0;
    if (!en) begin
      state_n   = CAP_IDLE;
      bitcnt_n  = '0;
      half_ok_n = 1'b0;
    end else begin
      case (state)
        CAP_IDLE: state_n = CAP_ALIGN;
        CAP_ALIGN: begin
          if (lr_edge) begin
            state_n  = CAP_SHIFT;
            chan_n   = lr_s;
            bitcnt_n = '0;
            shift_n  = '0;
          end
        end
        CAP_SHIFT: begin
          if (lr_edge) begin
            // Word boundary: keep a full chan0 word, complete on a full chan1.
            if (bitcnt == CNT_W'(WORD_W)) begin
              if (!chan) begin
                low_n     = shift_q;
                half_ok_n = 1'b1;
              end else if (half_ok) begin
                frame_push = 1'b1;
                half_ok_n  = 1'b0;
              end
            end else begin
              half_ok_n = 1'b0;
            end
            chan_n   = lr_s;
            bitcnt_n = '0;
            shift_n  = '0;
          end else if (bclk_rise && bitcnt < CNT_W'(WORD_W)) begin
            shift_n  = {shift_q[WORD_W-2:0], data_s};
            bitcnt_n = bitcnt + 1'b1;
          end
        end
        default: state_n = CAP_IDLE;
      endcase
    end
  end

  assign busy = (state != CAP_IDLE);

  // ---------------- frame FIFO ----------------
  logic [FRAME_W-1:0]      fifo_head;
  logic                    fifo_empty, fifo_full, fifo_drop, fifo_pop, evb_pop;
  logic [$clog2(DEPTH):0]  fifo_level;

  i2s_rx_fifo #(.DEPTH(DEPTH), .WIDTH(FRAME_W)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (frame_push),
    .push_data ({shift_q, low_q}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .level     (fifo_level),
    .drop      (fifo_drop)
  );

  assign rx_valid = ~fifo_empty;
  assign rx_data  = fifo_head;
  // Stream and EVB pops collapse into one; both see the same head.
  assign fifo_pop = (rx_valid & rx_ready) | evb_pop;

  // ---------------- EVB register port ----------------
  logic        accept, status_wr;
  logic [31:0] status_word, rd_val;

  assign accept      = evb_cmd_request & ~evb_cmd_finish;
  assign status_word = {28'h0, overflow, fifo_empty, en, busy};
  assign status_wr   = accept && (evb_cmd_addr == RX_STATUS_ISSUE) &&
                       (evb_cmd_wr_mask != EVB_MASK_DUMMY);
  assign evb_pop     = accept && (evb_cmd_addr == RX_DATA_ISSUE) &&
                       (evb_cmd_wr_mask == EVB_MASK_DUMMY);

  always_comb begin
    rd_val = '0;
    case (evb_cmd_addr)
      RX_STATUS_ISSUE: rd_val = status_word;
      RX_LEVEL_ISSUE:  rd_val = 32'(fifo_level);
      RX_DATA_ISSUE:   rd_val = fifo_head;
      default:         rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evb_cmd_finish  <= 1'b0;
      evb_cmd_rd_data <= '0;
      en              <= 1'b0;
      overflow        <= 1'b0;
    end else begin
      evb_cmd_finish  <= accept;
      evb_cmd_rd_data <= accept ? rd_val : '0;
      if (status_wr)
        en <= evb_wr_bit(evb_cmd_wr_mask, status_word, evb_cmd_wr_data, ST_EN);
      if (fifo_drop)
        overflow <= 1'b1;
      else if (status_wr &&
               evb_wr_bit(evb_cmd_wr_mask, status_word, evb_cmd_wr_data, ST_OVF))
        overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_i2s_rx.sv
// Directed/randomised bench for i2s_rx with a word-level reference model.
module tb_i2s_rx;
  import i2s_rx_pkg::*;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        bclk, lrclk, sdata;
  logic        evb_cmd_request;
  logic [3:0]  evb_cmd_addr;
  logic [1:0]  evb_cmd_wr_mask;
  logic [31:0] evb_cmd_wr_data;
  logic        evb_cmd_finish;
  logic [31:0] evb_cmd_rd_data;
  logic        rx_valid;
  logic [31:0] rx_data;
  logic        rx_ready;

  always #5 clk = ~clk;

  i2s_rx #(.DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
    .clk             (clk),
    .rst             (rst),
    .io_i2s_bclk     (bclk),
    .io_i2s_lrclk    (lrclk),
    .io_i2s_data     (sdata),
    .evb_cmd_request (evb_cmd_request),
    .evb_cmd_addr    (evb_cmd_addr),
    .evb_cmd_wr_mask (evb_cmd_wr_mask),
    .evb_cmd_wr_data (evb_cmd_wr_data),
    .evb_cmd_finish  (evb_cmd_finish),
    .evb_cmd_rd_data (evb_cmd_rd_data),
    .rx_valid        (rx_valid),
    .rx_data         (rx_data),
    .rx_ready        (rx_ready)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: whole words and frames, evaluated at each lrclk change.
  logic [31:0] exp_q[$];
  bit          m_en = 0;
  bit          m_ovf = 0;
  bit          cur_valid = 0;
  bit          cur_ch = 0;
  bit          c0_ok = 0;
  logic [15:0] cur_val = '0;
  logic [15:0] c0_val = '0;
  int          cur_bits = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model_edge();
    if (m_en && cur_valid) begin
      if (cur_bits >= 16) begin
        if (!cur_ch) begin
          c0_ok  = 1;
          c0_val = cur_val;
        end else if (c0_ok) begin
          if (exp_q.size() < DEPTH) exp_q.push_back({cur_val, c0_val});
          else m_ovf = 1;
          c0_ok = 0;
        end
      end else begin
        c0_ok = 0;
      end
    end
  endtask

  task automatic start_word(input bit ch, input logic [15:0] val);
    if (lrclk !== ch) begin
      model_edge();
      lrclk     = ch;
      cur_valid = m_en;
      cur_ch    = ch;
      cur_bits  = 0;
    end
    cur_val = val;
  endtask

  task automatic send_bits(input logic [15:0] val, input int msb, input int n);
    for (int i = 0; i < n; i++) begin
      sdata = val[msb-i];
      repeat (4) @(negedge clk);
      bclk = 1'b1;
      cur_bits++;
      repeat (4) @(negedge clk);
      bclk = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [15:0] c0, input logic [15:0] c1);
    start_word(1'b0, c0);
    send_bits(c0, 15, 16);
    start_word(1'b1, c1);
    send_bits(c1, 15, 16);
  endtask

  task automatic tail();
    start_word(1'b0, 16'h0);
    repeat (8) @(negedge clk);
  endtask

  task automatic evb(input logic [3:0] a, input logic [1:0] m, input logic [31:0] wd,
                     input bit with_pop, output logic [31:0] rd);
    bit got;
    @(negedge clk);
    evb_cmd_request = 1'b1;
    evb_cmd_addr    = a;
    evb_cmd_wr_mask = m;
    evb_cmd_wr_data = wd;
    if (with_pop) rx_ready = 1'b1;
    got = 0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      rx_ready = 1'b0;
      got = evb_cmd_finish;
    end
    chk("evb_finish", 32'(got), 32'd1);
    rd = evb_cmd_rd_data;
    @(negedge clk);
    chk("evb_finish_pulse", 32'(evb_cmd_finish), 32'd0);
    evb_cmd_request = 1'b0;
  endtask

  task automatic check_level(input string tag);
    logic [31:0] rd;
    evb(RX_LEVEL_ISSUE, EVB_MASK_DUMMY, 32'h0, 0, rd);
    chk(tag, rd, 32'(exp_q.size()));
  endtask

  task automatic pop_stream(input string tag);
    chk({tag, "_valid"}, 32'(rx_valid), 32'd1);
    if (exp_q.size() > 0) chk({tag, "_data"}, rx_data, exp_q[0]);
    @(negedge clk);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    if (exp_q.size() > 0) void'(exp_q.pop_front());
  endtask

  function automatic logic [31:0] exp_status();
    return {28'h0, m_ovf, (exp_q.size() == 0), m_en, m_en};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [15:0] a, b;

    rst = 1'b1; rx_ready = 1'b0; evb_cmd_request = 1'b0;
    evb_cmd_addr = '0; evb_cmd_wr_mask = '0; evb_cmd_wr_data = '0;
    bclk = 1'b0; lrclk = 1'b0; sdata = 1'b0;

    // Reset with the I2S pins toggling.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      bclk = 1'($urandom); lrclk = 1'($urandom); sdata = 1'($urandom);
      if (i == 7 || i == 15) begin
        chk("rst_rx_valid", 32'(rx_valid), 32'd0);
        chk("rst_rx_data", rx_data, 32'h0);
        chk("rst_finish", 32'(evb_cmd_finish), 32'd0);
        chk("rst_rd_data", evb_cmd_rd_data, 32'h0);
      end
    end
    bclk = 1'b0; lrclk = 1'b1; sdata = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("post_rst_rx_valid", 32'(rx_valid), 32'd0);
    check_level("rst_level");
    evb(RX_STATUS_ISSUE, EVB_MASK_DUMMY, 32'h0, 0, rd);
    chk("rst_status", rd, 32'h4);

    // Enable and basic frame.
    evb(RX_STATUS_ISSUE, EVB_MASK_W, 32'h2, 0, rd);
    m_en = 1;
    evb(RX_STATUS_ISSUE, EVB_MASK_DUMMY, 32'h0, 0, rd);
    chk("en_status", rd, exp_status());
    send_frame(16'h1234, 16'hABCD);
    tail();
    chk("basic_valid", 32'(rx_valid), 32'd1);
    chk("basic_data", rx_data, 32'hABCD1234);
    check_level("basic_level");
    pop_stream("basic_pop");
    chk("basic_empty", 32'(rx_valid), 32'd0);

    // Overflow: DEPTH+1 random frames without pops.
    for (int f = 0; f <= DEPTH; f++) begin
      a = 16'($urandom); b = 16'($urandom);
      send_frame(a, b);
    end
    tail();
    check_level("ovf_level");
    evb(RX_STATUS_ISSUE, EVB_MASK_DUMMY, 32'h0, 0, rd);
    chk("ovf_status", rd, exp_status());
    chk("ovf_head", rx_data, exp_q[0]);
    evb(RX_STATUS_ISSUE, EVB_MASK_W, 32'hA, 0, rd);
    m_ovf = 0;
    evb(RX_STATUS_ISSUE, EVB_MASK_DUMMY, 32'h0, 0, rd);
    chk("ovf_clr_status", rd, exp_status());
    for (int f = 0; f < DEPTH; f++) pop_stream("ovf_drain");
    chk("ovf_drained", 32'(rx_valid), 32'd0);

    // Short chan0 word: no push; next full pair is fine.
    a = 16'($urandom); b = 16'($urandom);
    start_word(1'b0, a);
    send_bits(a, 15, 10);
    start_word(1'b1, b);
    send_bits(b, 15, 16);
    tail();
    chk("short_valid", 32'(rx_valid), 32'(exp_q.size() != 0));
    check_level("short_level");
    send_frame(16'($urandom), 16'($urandom));
    tail();
    check_level("short_next_level");
    pop_stream("short_next_pop");

    // Disable mid chan0, re-enable mid chan1.
    a = 16'($urandom); b = 16'($urandom);
    start_word(1'b0, a);
    send_bits(a, 15, 8);
    evb(RX_STATUS_ISSUE, EVB_MASK_W, 32'h0, 0, rd);
    m_en = 0; cur_valid = 0; c0_ok = 0;
    start_word(1'b1, b);
    send_bits(b, 15, 8);
    evb(RX_STATUS_ISSUE, EVB_MASK_W, 32'h2, 0, rd);
    m_en = 1;
    send_bits(b, 7, 8);
    a = 16'($urandom); b = 16'($urandom);
    send_frame(a, b);
    chk("dis_no_push", 32'(rx_valid), 32'(exp_q.size() != 0));
    tail();
    chk("dis_frame", rx_data, {b, a});
    check_level("dis_level");

    // Concurrent stream pop + EVB DATA read.
    send_frame(16'($urandom), 16'($urandom));
    tail();
    check_level("cc_level2");
    evb(RX_DATA_ISSUE, EVB_MASK_DUMMY, 32'h0, 1, rd);
    chk("cc_rd_head", rd, exp_q[0]);
    void'(exp_q.pop_front());
    check_level("cc_level1");
    chk("cc_new_head", rx_data, exp_q[0]);
    evb(RX_STATUS_ISSUE, EVB_MASK_H, 32'h0000_0000, 0, rd);
    evb(RX_STATUS_ISSUE, EVB_MASK_DUMMY, 32'h0, 0, rd);
    chk("h_write_status", rd, exp_status());
    evb(RX_DATA_ISSUE, EVB_MASK_DUMMY, 32'h0, 0, rd);
    chk("evb_data_read", rd, exp_q[0]);
    void'(exp_q.pop_front());
    evb(RX_DATA_ISSUE, EVB_MASK_DUMMY, 32'h0, 0, rd);
    chk("evb_data_empty", rd, 32'h0);
    chk("final_empty", 32'(rx_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
